// File: rtl/fetch_stage.sv
// Instruction-fetch front end: issues sequential word addresses to a one-cycle
// latency instruction memory, handles redirects and buffers returns in a 2-entry skid FIFO.
module fetch_stage #(
    parameter int                ISIZE    = 16,
    parameter int                DSIZE    = 32,
    parameter logic [ISIZE-1:0]  RESET_PC = {ISIZE{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ISIZE-1:0] imem_addr,
    output logic             imem_wen,
    input  logic [DSIZE-1:0] imem_rdata,
    input  logic             fetch_en,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_instr,
    output logic [ISIZE-1:0] out_pc
);

    logic [ISIZE-1:0] r_pc;
    logic             r_req_v;
    logic [ISIZE-1:0] r_req_pc;
    logic [DSIZE-1:0] r_fifo_instr [0:1];
    logic [ISIZE-1:0] r_fifo_pc    [0:1];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic             w_deq;
    logic             w_push;
    logic             w_issue;
    logic [2:0]       w_occ;

    // Occupancy after this cycle's dequeue, counting the fetch still in flight;
    // issuing only while it is <= 1 guarantees every returned word finds a slot.
    assign w_deq   = out_valid & out_ready;
    assign w_occ   = {1'b0, r_count} + {2'b00, r_req_v} - {2'b00, w_deq};
    assign w_issue = fetch_en & ~redirect_valid & (w_occ <= 3'd1);
    assign w_push  = r_req_v & ~redirect_valid;

    assign imem_addr = r_pc;
    assign imem_wen  = 1'b0;
    assign out_valid = (r_count != 2'd0);
    assign out_instr = r_fifo_instr[r_rd_ptr];
    assign out_pc    = r_fifo_pc[r_rd_ptr];

    // PC, in-flight request tracking and FIFO state; redirect flushes everything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_req_v         <= 1'b0;
            r_req_pc        <= {ISIZE{1'b0}};
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_fifo_instr[0] <= {DSIZE{1'b0}};
            r_fifo_instr[1] <= {DSIZE{1'b0}};
            r_fifo_pc[0]    <= {ISIZE{1'b0}};
            r_fifo_pc[1]    <= {ISIZE{1'b0}};
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_req_v  <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_issue) begin
                r_pc     <= r_pc + {{(ISIZE-1){1'b0}}, 1'b1};
                r_req_v  <= 1'b1;
                r_req_pc <= r_pc;
            end else begin
                r_req_v  <= 1'b0;
            end
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= imem_rdata;
                r_fifo_pc[r_wr_ptr]    <= r_req_pc;
                r_wr_ptr               <= ~r_wr_ptr;
            end else begin
                r_wr_ptr               <= r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_deq};
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a cycle table for startup/backpressure/redirect/reset, a random
// scoreboard stream, and a wrap-around stream on a second instance with RESET_PC=0xFFFE.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return 32'h0000_1000 + {16'h0000, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instance A (RESET_PC = 0) ----------------
    logic        rst, fe, rdy, redir;
    logic [15:0] rpc;
    logic [15:0] addr_a;
    logic        wen_a;
    logic [31:0] rdata_a;
    logic        valid_a;
    logic [31:0] instr_a;
    logic [15:0] pc_a;

    fetch_stage #(.ISIZE(16), .DSIZE(32), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .imem_addr(addr_a), .imem_wen(wen_a), .imem_rdata(rdata_a),
        .fetch_en(fe), .redirect_valid(redir), .redirect_pc(rpc),
        .out_valid(valid_a), .out_ready(rdy), .out_instr(instr_a), .out_pc(pc_a)
    );

    always @(posedge clk) rdata_a <= mem_f(addr_a);

    // ---------------- instance B (RESET_PC = 0xFFFE) ----------------
    logic        rst_b, rdy_b;
    logic [15:0] addr_b;
    logic        wen_b;
    logic [31:0] rdata_b;
    logic        valid_b;
    logic [31:0] instr_b;
    logic [15:0] pc_b;
    logic        fe_b    = 1'b1;
    logic        redir_b = 1'b0;
    logic [15:0] rpc_b   = 16'h0000;

    fetch_stage #(.ISIZE(16), .DSIZE(32), .RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst_b), .imem_addr(addr_b), .imem_wen(wen_b), .imem_rdata(rdata_b),
        .fetch_en(fe_b), .redirect_valid(redir_b), .redirect_pc(rpc_b),
        .out_valid(valid_b), .out_ready(rdy_b), .out_instr(instr_b), .out_pc(pc_b)
    );

    always @(posedge clk) rdata_b <= mem_f(addr_b);

    // ---------------- scoreboards ----------------
    logic [15:0] sb_q[$];
    logic [15:0] sb_b_q[$];
    logic        sb_en   = 1'b0;
    logic        sb_b_en = 1'b0;
    int          n_deliv = 0;
    logic        prev_hold  = 1'b0;
    logic [15:0] prev_pc;
    logic [31:0] prev_instr;

    always @(negedge clk) begin
        if (sb_en) begin
            if (prev_hold) begin
                chk("hold_valid", valid_a, 1'b1);
                chk("hold_pc", pc_a, prev_pc);
                chk("hold_instr", instr_a, prev_instr);
            end
            if (valid_a && rdy) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL sb_underrun: delivered pc=%0h with nothing expected", pc_a);
                end else begin
                    logic [15:0] e;
                    e = sb_q.pop_front();
                    chk("sb_pc", pc_a, e);
                    chk("sb_instr", instr_a, mem_f(e));
                    n_deliv++;
                end
            end
            prev_hold  = valid_a && !rdy && !redir && !rst;
            prev_pc    = pc_a;
            prev_instr = instr_a;
        end
    end

    always @(negedge clk) begin
        if (sb_b_en && valid_b && rdy_b) begin
            if (sb_b_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL sb_b_underrun: delivered pc=%0h with nothing expected", pc_b);
            end else begin
                logic [15:0] e;
                e = sb_b_q.pop_front();
                chk("wrap_pc", pc_b, e);
                chk("wrap_instr", instr_b, mem_f(e));
            end
        end
    end

    // ---------------- cycle table ----------------
    typedef struct {
        logic        rst, fe, rdy, redir;
        logic [15:0] rpc;
        logic        ev, cd;
        logic [15:0] epc;
        logic [31:0] ei;
        logic [15:0] ea;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic f, input logic y, input logic d,
                       input logic [15:0] p, input logic ev, input logic cd,
                       input logic [15:0] epc, input logic [15:0] ea);
        vec_t v;
        v.rst = r; v.fe = f; v.rdy = y; v.redir = d; v.rpc = p;
        v.ev = ev; v.cd = cd; v.epc = epc; v.ea = ea;
        v.ei = ev ? mem_f(epc) : 32'h0000_0000;
        tbl.push_back(v);
    endtask

    initial begin
        //   rst  fe   rdy  rdr  rpc        ev   cd   epc        ea
        add(1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h0000, 16'h0000); // 0 reset state
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b1,16'h0000, 16'h0000); // 1 T: first issue
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0001); // 2
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0000, 16'h0002); // 3 T+2 valid
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0001, 16'h0003);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0002, 16'h0004);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0003, 16'h0005);
        for (int i = 0; i < 5; i++)                                       // 7..11 stall at pc 4
            add(1'b0,1'b1,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0004, 16'h0006);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0004, 16'h0006); // 12 release
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0005, 16'h0007);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0006, 16'h0008);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0007, 16'h0009);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0008, 16'h000A);
        add(1'b0,1'b1,1'b1,1'b1,16'h0100, 1'b1,1'b1,16'h0009, 16'h000B); // 17 redirect + deq pc 9
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0100);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0101);
        add(1'b0,1'b1,1'b0,1'b0,16'h0000, 1'b1,1'b1,16'h0100, 16'h0102); // 20 T+3 target
        add(1'b0,1'b1,1'b0,1'b1,16'h0040, 1'b1,1'b1,16'h0100, 16'h0102); // 21 redirect when full
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0040);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0041);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0040, 16'h0042);
        add(1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0041, 16'h0043); // 25 fetch_en low
        add(1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0042, 16'h0043);
        add(1'b0,1'b0,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0043);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0043);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0044);
        add(1'b1,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0043, 16'h0045); // 30 rst mid-stream
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b1,16'h0000, 16'h0000);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0000, 16'h0001);
        add(1'b0,1'b1,1'b1,1'b0,16'h0000, 1'b1,1'b1,16'h0000, 16'h0002);

        rst = 1'b1; fe = 1'b0; rdy = 1'b0; redir = 1'b0; rpc = 16'h0000;
        rst_b = 1'b1; rdy_b = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; fe = tbl[i].fe; rdy = tbl[i].rdy;
            redir = tbl[i].redir; rpc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("row%0d_valid", i), valid_a, tbl[i].ev);
            chk($sformatf("row%0d_addr", i), addr_a, tbl[i].ea);
            chk($sformatf("row%0d_wen", i), wen_a, 1'b0);
            if (tbl[i].cd) begin
                chk($sformatf("row%0d_pc", i), pc_a, tbl[i].epc);
                chk($sformatf("row%0d_instr", i), instr_a, tbl[i].ei);
            end
        end

        // Random backpressure / fetch_en / redirect stream against the scoreboard.
        @(posedge clk); #1;
        rst = 1'b1; fe = 1'b0; rdy = 1'b0; redir = 1'b0;
        @(posedge clk); #1;
        sb_q.delete();
        for (int k = 0; k < 600; k++) sb_q.push_back(16'(k));
        rst = 1'b0;
        sb_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            fe    = ($urandom_range(0, 9) != 0);
            rdy   = ($urandom_range(0, 2) != 0);
            redir = (c > 20) && ($urandom_range(0, 39) == 0);
            rpc   = 16'($urandom);
            @(posedge clk); #1;
            if (redir) begin
                sb_q.delete();
                for (int k = 0; k < 600; k++) sb_q.push_back(16'(rpc + 16'(k)));
            end
        end
        redir = 1'b0; fe = 1'b0; rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        sb_en = 1'b0;
        chk("random_progress", (n_deliv > 100), 1'b1);
        rdy = 1'b0;

        // Wrap-around: RESET_PC=0xFFFE, free-running with no gaps.
        for (int k = 0; k < 8; k++) sb_b_q.push_back(16'(16'hFFFE + 16'(k)));
        sb_b_en = 1'b1;
        rdy_b = 1'b1;
        rst_b = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rdy_b = 1'b0;
        chk("wrap_all_delivered", sb_b_q.size(), 0);
        @(negedge clk);
        chk("wrap_next_pc", pc_b, 16'h0006);
        sb_b_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
